// File: rtl/alu_seq_if.sv
// Handshake bundle between operand issue (master) and the sequential ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
               zero, carry, negative, overflow, illegal, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
               zero, carry, negative, overflow, illegal, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops through a registered output stage, iterative shift-add MUL/MULU
// and restoring DIVU. Define ALU_SEQ_DIV_EN to build the divider; otherwise DIVU decodes as illegal.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [4:0] OP_ADDU  = 5'b00000;
    localparam logic [4:0] OP_SUBU  = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00011;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_NOR   = 5'b00111;
    localparam logic [4:0] OP_LUI   = 5'b01000;
    localparam logic [4:0] OP_PASSA = 5'b01001;
    localparam logic [4:0] OP_SLTU  = 5'b01010;
    localparam logic [4:0] OP_SLT   = 5'b01011;
    localparam logic [4:0] OP_SRA   = 5'b01100;
    localparam logic [4:0] OP_SRL   = 5'b01101;
    localparam logic [4:0] OP_SLL   = 5'b01110;
    localparam logic [4:0] OP_ROR   = 5'b01111;
    localparam logic [4:0] OP_MULU  = 5'b10000;
    localparam logic [4:0] OP_MUL   = 5'b10001;
    localparam logic [4:0] OP_DIVU  = 5'b10010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] result_reg, result_hi_reg;
    logic             zero_reg, carry_reg, negative_reg, overflow_reg, illegal_reg;

    logic             out_free, in_ready_c, accept, iter_op;
    logic             load_single, load_iter, step_en;

    logic [WIDTH-1:0] opa, opb;
    logic [SW-1:0]    sh;
    assign opa = bus.a;
    assign opb = bus.b;
    assign sh  = opa[SW-1:0];

    assign out_free = !out_valid_reg || bus.out_ready;

`ifdef ALU_SEQ_DIV_EN
    assign iter_op = (bus.op == OP_MULU) || (bus.op == OP_MUL) || (bus.op == OP_DIVU);
`else
    assign iter_op = (bus.op == OP_MULU) || (bus.op == OP_MUL);
`endif

    // The first iteration step happens on the accepting edge, so RUN plus HOLD
    // together span exactly WIDTH edges before the result lands.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        in_ready_c = 1'b0;
        load_iter  = 1'b0;
        step_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = out_free;
                if (bus.in_valid && out_free && iter_op) begin
                    state_next = RUN;
                    cnt_next   = CW'(1);
                    step_en    = 1'b1;
                end
            end
            RUN: begin
                step_en  = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_free) begin
                    load_iter  = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign accept      = bus.in_valid && in_ready_c;
    assign load_single = accept && !iter_op;

    logic [WIDTH:0]   add_w, sub_w, srl_w, sll_w;
    logic [CW-1:0]    rsh;
    logic [WIDTH-1:0] s_res;
    logic             s_carry, s_ovf, s_ill;

    assign add_w = {1'b0, opa} + {1'b0, opb};
    assign sub_w = {1'b0, opa} - {1'b0, opb};
    // One guard bit on each side captures the last bit shifted out (0 for amount 0).
    assign srl_w = {opb, 1'b0} >> sh;
    assign sll_w = {1'b0, opb} << sh;
    assign rsh   = CW'(WIDTH) - CW'(sh);

    always_comb begin
        s_res   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_ill   = 1'b0;
        case (bus.op)
            OP_ADDU: begin
                s_res   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
            end
            OP_SUBU: begin
                s_res   = sub_w[WIDTH-1:0];
                s_carry = sub_w[WIDTH];
            end
            OP_ADD: begin
                s_res   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (opa[WIDTH-1] == opb[WIDTH-1]) && (add_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                s_res   = sub_w[WIDTH-1:0];
                s_carry = sub_w[WIDTH];
                s_ovf   = (opa[WIDTH-1] != opb[WIDTH-1]) && (sub_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND:   s_res = opa & opb;
            OP_OR:    s_res = opa | opb;
            OP_XOR:   s_res = opa ^ opb;
            OP_NOR:   s_res = ~(opa | opb);
            OP_LUI:   s_res = opb << (WIDTH / 2);
            OP_PASSA: s_res = opa;
            OP_SLTU:  s_res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
            OP_SLT:   s_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_SRA: begin
                s_res   = $signed(opb) >>> sh;
                s_carry = srl_w[0];
            end
            OP_SRL: begin
                s_res   = srl_w[WIDTH:1];
                s_carry = srl_w[0];
            end
            OP_SLL: begin
                s_res   = sll_w[WIDTH-1:0];
                s_carry = sll_w[WIDTH];
            end
            OP_ROR: begin
                s_res   = (opb >> sh) | (opb << rsh);
                s_carry = srl_w[0];
            end
            default: s_ill = 1'b1;
        endcase
    end

    // Shift-add multiplier on operand magnitudes; the product sign is applied at the end.
    logic [2*WIDTH-1:0] mcand_reg, mcand_src, mcand_next;
    logic [2*WIDTH-1:0] prod_reg, prod_src, prod_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_src, mplier_next;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_reg;
    logic [1:0]         kind_reg;
    logic               mul_signed;

    assign mul_signed = (bus.op == OP_MUL);
    assign a_mag = (mul_signed && opa[WIDTH-1]) ? -opa : opa;
    assign b_mag = (mul_signed && opb[WIDTH-1]) ? -opb : opb;

    always_comb begin
        if (state_reg == IDLE) begin
            mcand_src  = {{WIDTH{1'b0}}, a_mag};
            mplier_src = b_mag;
            prod_src   = '0;
        end else begin
            mcand_src  = mcand_reg;
            mplier_src = mplier_reg;
            prod_src   = prod_reg;
        end
        prod_next   = prod_src + (mplier_src[0] ? mcand_src : '0);
        mcand_next  = mcand_src << 1;
        mplier_next = mplier_src >> 1;
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] rem_reg, rem_src, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_src, quo_next;
    logic [WIDTH-1:0] dvs_reg, dvs_src;
    logic [WIDTH:0]   rem_sh, trial;

    // Restoring division: keep the trial difference only when it does not go negative.
    always_comb begin
        if (state_reg == IDLE) begin
            rem_src = '0;
            quo_src = opa;
            dvs_src = opb;
        end else begin
            rem_src = rem_reg;
            quo_src = quo_reg;
            dvs_src = dvs_reg;
        end
        rem_sh = {rem_src, quo_src[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_src};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo_src[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo_src[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg <= '0;
            quo_reg <= '0;
            dvs_reg <= '0;
        end else if (step_en) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            dvs_reg <= dvs_src;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            neg_reg    <= 1'b0;
            kind_reg   <= 2'b00;
        end else begin
            if (step_en) begin
                mcand_reg  <= mcand_next;
                mplier_reg <= mplier_next;
                prod_reg   <= prod_next;
            end
            if (accept && iter_op) begin
                kind_reg <= bus.op[1:0];
                neg_reg  <= mul_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            end
        end
    end

    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   it_res, it_hi;
    logic               it_ovf;

    always_comb begin
        prod_fin = neg_reg ? -prod_reg : prod_reg;
        it_res   = '0;
        it_hi    = '0;
        it_ovf   = 1'b0;
        case (kind_reg)
            2'b00: begin
                it_res = prod_fin[WIDTH-1:0];
                it_hi  = prod_fin[2*WIDTH-1:WIDTH];
                it_ovf = |prod_fin[2*WIDTH-1:WIDTH];
            end
            2'b01: begin
                it_res = prod_fin[WIDTH-1:0];
                it_hi  = prod_fin[2*WIDTH-1:WIDTH];
                it_ovf = prod_fin[2*WIDTH-1:WIDTH] != {WIDTH{prod_fin[WIDTH-1]}};
            end
`ifdef ALU_SEQ_DIV_EN
            2'b10: begin
                it_res = quo_reg;
                it_hi  = rem_reg;
                it_ovf = (dvs_reg == '0);
            end
`endif
            default: ;
        endcase
    end

    logic [WIDTH-1:0] ld_res, ld_hi;
    logic             ld_carry, ld_ovf, ld_ill;

    always_comb begin
        ld_res   = load_iter ? it_res : s_res;
        ld_hi    = load_iter ? it_hi : '0;
        ld_carry = load_iter ? 1'b0 : s_carry;
        ld_ovf   = load_iter ? it_ovf : s_ovf;
        ld_ill   = load_iter ? 1'b0 : s_ill;
        if (load_single || load_iter) begin
            out_valid_next = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end else begin
            out_valid_next = out_valid_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            negative_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            out_valid_reg <= out_valid_next;
            if (load_single || load_iter) begin
                result_reg    <= ld_res;
                result_hi_reg <= ld_hi;
                zero_reg      <= !ld_ill && (ld_res == '0);
                carry_reg     <= ld_carry;
                negative_reg  <= ld_res[WIDTH-1];
                overflow_reg  <= ld_ovf;
                illegal_reg   <= ld_ill;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.result_hi = result_hi_reg;
    assign bus.zero      = zero_reg;
    assign bus.carry     = carry_reg;
    assign bus.negative  = negative_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.illegal   = illegal_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against an arithmetic reference model and scoreboard,
// plus directed literal cases (honours ALU_SEQ_DIV_EN the same way as the design).
module tb_alu_seq;
    localparam int W = 32;

    localparam logic [4:0] OP_ADDU = 5'b00000, OP_SUBU = 5'b00001, OP_ADD = 5'b00010, OP_SUB = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100, OP_OR = 5'b00101, OP_XOR = 5'b00110, OP_NOR = 5'b00111;
    localparam logic [4:0] OP_LUI = 5'b01000, OP_PASSA = 5'b01001, OP_SLTU = 5'b01010, OP_SLT = 5'b01011;
    localparam logic [4:0] OP_SRA = 5'b01100, OP_SRL = 5'b01101, OP_SLL = 5'b01110, OP_ROR = 5'b01111;
    localparam logic [4:0] OP_MULU = 5'b10000, OP_MUL = 5'b10001, OP_DIVU = 5'b10010;
    localparam longint SMAX = 64'sh7fffffff;
    localparam longint SMIN = -64'sh80000000;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] hi;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    function automatic exp_t mk(input logic [31:0] r, hi, input logic z, c, n, v, ill);
        exp_t e;
        e.r = r; e.hi = hi; e.z = z; e.c = c; e.n = n; e.v = v; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, y);
        exp_t e;
        int sh;
        longint s;
        logic [63:0] p;
        logic [32:0] w;
        logic [31:0] t;
        e = '0;
        sh = int'(x[4:0]);
        case (o)
            OP_ADDU, OP_ADD: begin
                w = {1'b0, x} + {1'b0, y};
                e.r = w[31:0]; e.c = w[32];
                if (o == OP_ADD) begin
                    s = longint'($signed(x)) + longint'($signed(y));
                    e.v = (s > SMAX) || (s < SMIN);
                end
            end
            OP_SUBU, OP_SUB: begin
                e.r = x - y; e.c = (x < y);
                if (o == OP_SUB) begin
                    s = longint'($signed(x)) - longint'($signed(y));
                    e.v = (s > SMAX) || (s < SMIN);
                end
            end
            OP_AND:   e.r = x & y;
            OP_OR:    e.r = x | y;
            OP_XOR:   e.r = x ^ y;
            OP_NOR:   e.r = ~(x | y);
            OP_LUI:   e.r = y << 16;
            OP_PASSA: e.r = x;
            OP_SLTU:  e.r = (x < y) ? 32'd1 : 32'd0;
            OP_SLT:   e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SRA: begin
                e.r = $signed(y) >>> sh;
                if (sh != 0) e.c = y[sh-1];
            end
            OP_SRL: begin
                e.r = y >> sh;
                if (sh != 0) e.c = y[sh-1];
            end
            OP_SLL: begin
                e.r = y << sh;
                if (sh != 0) e.c = y[32-sh];
            end
            OP_ROR: begin
                t = y;
                for (int k = 0; k < sh; k++) t = {t[0], t[31:1]};
                e.r = t;
                if (sh != 0) e.c = y[sh-1];
            end
            OP_MULU: begin
                p = {32'b0, x} * {32'b0, y};
                e.r = p[31:0]; e.hi = p[63:32]; e.v = (p[63:32] != 0);
            end
            OP_MUL: begin
                s = longint'($signed(x)) * longint'($signed(y));
                p = s;
                e.r = p[31:0]; e.hi = p[63:32]; e.v = (s > SMAX) || (s < SMIN);
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                if (y == 0) begin
                    e.r = 32'hFFFFFFFF; e.hi = x; e.v = 1'b1;
                end else begin
                    e.r = x / y; e.hi = x % y;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        if (!e.ill) begin
            e.z = (e.r == 0);
            e.n = e.r[31];
        end
        return e;
    endfunction

    function automatic exp_t cur_out();
        return mk(bus.result, bus.result_hi, bus.zero, bus.carry, bus.negative, bus.overflow, bus.illegal);
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Scoreboard compare: outputs on every drain edge, and stability while stalled.
    exp_t held;
    bit   held_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && bus.out_valid) check("hold_stable", cur_out(), held);
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", 96'd1, 96'd0);
                end else begin
                    check("scoreboard", cur_out(), sbq.pop_front());
                end
                held_v = 1'b0;
            end else if (bus.out_valid) begin
                held   = cur_out();
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) sbq.push_back(model(bus.op, bus.a, bus.b));
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x, y, input bit rnd);
        int n;
        bit acc;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk); #1;
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 96'd0, 96'd1);
    endtask

    task automatic wait_valid(input int max, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && !(bus.busy && !bus.in_ready)) busy_ok = 1'b0;
        end while (!bus.out_valid && lat < max);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #600000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit bok;
        int seen;
        logic [4:0] ro;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.out_valid, bus.busy, cur_out()}, 96'd0);
        check("reset_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 0);
        wait_valid(5, lat, bok);
        check("add_latency", lat, 1);
        check("add_ovf", cur_out(), mk(32'h80000000, 0, 0, 0, 1, 1, 0));

        issue(OP_SUB, 32'd32, 32'd64, 0);
        wait_valid(5, lat, bok);
        check("sub_borrow", cur_out(), mk(32'hFFFFFFE0, 0, 0, 1, 1, 0, 0));

        issue(OP_SLT, 32'hFFFFFFE0, 32'd32, 0);
        wait_valid(5, lat, bok);
        check("slt", cur_out(), mk(32'd1, 0, 0, 0, 0, 0, 0));

        issue(OP_SLTU, 32'hFFFFFFE0, 32'd32, 0);
        wait_valid(5, lat, bok);
        check("sltu", cur_out(), mk(32'd0, 0, 1, 0, 0, 0, 0));

        issue(OP_SRA, 32'd4, 32'h80000000, 0);
        wait_valid(5, lat, bok);
        check("sra", cur_out(), mk(32'hF8000000, 0, 0, 0, 1, 0, 0));

        issue(OP_MUL, 32'hFFFFFFE0, 32'd64, 0);
        wait_valid(60, lat, bok);
        check("mul_latency", lat, 33);
        check("mul_busy_in_ready", bok, 1);
        check("mul", cur_out(), mk(32'hFFFFF800, 32'hFFFFFFFF, 0, 0, 1, 0, 0));

`ifdef ALU_SEQ_DIV_EN
        issue(OP_DIVU, 32'd100, 32'd7, 0);
        wait_valid(60, lat, bok);
        check("divu_latency", lat, 33);
        check("divu", cur_out(), mk(32'd14, 32'd2, 0, 0, 0, 0, 0));
        issue(OP_DIVU, 32'd15, 32'd0, 0);
        wait_valid(60, lat, bok);
        check("divu_zero", cur_out(), mk(32'hFFFFFFFF, 32'd15, 0, 0, 1, 1, 0));
`else
        issue(OP_DIVU, 32'd100, 32'd7, 0);
        wait_valid(5, lat, bok);
        check("divu_off_latency", lat, 1);
        check("divu_off", cur_out(), mk(0, 0, 0, 0, 0, 0, 1));
`endif

        // Backpressure: second ADDU waits while the first result is held.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = OP_ADDU; bus.a = 32'd10; bus.b = 32'd20;
        @(negedge clk);
        check("bp_first_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.a = 32'd5; bus.b = 32'd6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_stall", {bus.in_ready, bus.out_valid, bus.result}, {1'b0, 1'b1, 32'd30});
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_accept", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_second", {bus.out_valid, bus.result}, {1'b1, 32'd11});

        // Reset in the middle of a multiply.
        issue(OP_MULU, 32'd5, 32'd6, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {bus.out_valid, bus.busy, cur_out()}, 96'd0);
        check("async_reset_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen++;
        end
        check("aborted_no_result", seen, 0);

        issue(OP_ADDU, 32'd1, 32'd2, 0);
        wait_valid(5, lat, bok);
        check("post_reset_latency", lat, 1);
        check("post_reset_addu", cur_out(), mk(32'd3, 0, 0, 0, 0, 0, 0));

        issue(5'b11111, 32'h1234, 32'h5678, 0);
        wait_valid(5, lat, bok);
        check("illegal_op", {lat[7:0], cur_out()}, {8'd1, mk(0, 0, 0, 0, 0, 0, 1)});

        for (int t = 0; t < 300; t++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 19) ro = 5'(r);
            else ro = 5'($urandom_range(19, 31));
            issue(ro, pick(), pick(), 1);
        end

        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        seen = 0;
        while ((sbq.size() != 0 || bus.busy) && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        check("drain_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
